// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad conditioner.
//   - key_state_e   : digit-pad FSM state encoding
//   - BTN_*         : bit positions of the control buttons in btn_raw
//   - DB_CYCLES_DEFAULT / CNT_W_DEFAULT : default debounce length and counter width
//   - is_one_hot()  : true when exactly one digit bit is set
package keypad_pkg;

  localparam int unsigned NUM_KEYS = 10;
  localparam int unsigned NUM_BTN  = 5;

  localparam int unsigned BTN_READY = 0;
  localparam int unsigned BTN_SURE  = 1;
  localparam int unsigned BTN_SETUP = 2;
  localparam int unsigned BTN_WAIT  = 3;
  localparam int unsigned BTN_FIRE  = 4;

  // 10 ms at 25 kHz
  localparam int unsigned DB_CYCLES_DEFAULT = 250;
  localparam int unsigned CNT_W_DEFAULT     = 9;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_e;

  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: single-bit synchroniser + debouncer for one control button.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous raw button level (1 = pressed)
//   level      : registered debounced level
//   rise       : registered single-cycle pulse on the debounced 0->1 flip
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 250,
  parameter int unsigned CNT_W     = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stable state flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s   <= 1'b0;
      cnt <= '0;
    end else if (sync2 == s) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      s   <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // level delays s by one edge; rise compares s against that delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      level <= s;
      rise  <= s & ~level;
    end
  end

endmodule

// File: rtl/keypad_conditioner.sv
// keypad_conditioner: synchronises and debounces the 10-key digit pad and the
// five control buttons feeding numeric_code_detonator.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_raw    : raw digit keys, bit i = digit i, 1 = pressed
//   btn_raw    : raw controls {fire, wait_t, setup, sure, ready}, 1 = pressed
//   A          : one-hot single-cycle pulse per accepted digit press
//   ready, sure, setup, wait_t : single-cycle pulses on debounced press
//   fire       : debounced fire level
//   key_err    : only when KEYPAD_MULTI_ERR_EN is defined; single-cycle pulse
//                when a debounced press has two or more digit keys down
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_BTN-1:0]  btn_raw,
  output logic [NUM_KEYS-1:0] A,
  output logic                ready,
  output logic                sure,
  output logic                setup,
  output logic                wait_t,
  output logic                fire
`ifdef KEYPAD_MULTI_ERR_EN
  ,
  output logic                key_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NUM_KEYS-1:0] ks_meta;
  logic [NUM_KEYS-1:0] ks;
  key_state_e          state;
  key_state_e          state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [NUM_KEYS-1:0] cap;
  logic [NUM_KEYS-1:0] cap_nxt;
  logic                press_done_c;

  // Two-flop synchroniser for the whole digit vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_meta <= '0;
      ks      <= '0;
    end else begin
      ks_meta <= key_raw;
      ks      <= ks_meta;
    end
  end

  // Digit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cap   <= cap_nxt;
    end
  end

  // Digit FSM next state; the release leg never emits, so bounces cannot repeat a digit
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cap_nxt      = cap;
    press_done_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (ks != '0) begin
          cap_nxt   = ks;
          cnt_nxt   = '0;
          state_nxt = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (ks != cap) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt    = HELD;
          press_done_c = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (ks == '0) begin
          cnt_nxt   = '0;
          state_nxt = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (ks != '0) begin
          state_nxt = HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit output: only a single-key capture produces a pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A <= '0;
    end else begin
      A <= (press_done_c && is_one_hot(cap)) ? cap : '0;
    end
  end

`ifdef KEYPAD_MULTI_ERR_EN
  // Multi-key error pulse, aligned with where A would have pulsed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_err <= 1'b0;
    end else begin
      key_err <= press_done_c & ~is_one_hot(cap);
    end
  end
`endif

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] rise_w;

  // One independent debouncer per control button
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (level_w[i]),
      .rise  (rise_w[i])
    );
  end

  assign ready  = rise_w[BTN_READY];
  assign sure   = rise_w[BTN_SURE];
  assign setup  = rise_w[BTN_SETUP];
  assign wait_t = rise_w[BTN_WAIT];
  assign fire   = level_w[BTN_FIRE];

  // Pulse-only buttons do not need their level, fire does not need its edge
  logic unused_btn;
  assign unused_btn = ^{level_w[BTN_WAIT:BTN_READY], rise_w[BTN_FIRE]};

endmodule

// File: tb/tb_keypad_conditioner.sv
module tb_keypad_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_raw;
  logic [4:0] btn_raw;
  logic [9:0] A;
  logic       ready, sure, setup, wait_t, fire;
`ifdef KEYPAD_MULTI_ERR_EN
  logic       key_err;
`endif

  keypad_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .btn_raw (btn_raw),
    .A       (A),
    .ready   (ready),
    .sure    (sure),
    .setup   (setup),
    .wait_t  (wait_t),
    .fire    (fire)
`ifdef KEYPAD_MULTI_ERR_EN
    ,
    .key_err (key_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic [9:0] a_q[$];
  int         a_t[$];
  logic [9:0] a_prev = '0;
  int wide_n = 0;
  int rdy_n, rdy_t, sure_n, setup_n, setup_t, wait_n, err_n, err_t;
  int fire_rise_t, fire_fall_t;
  logic fire_prev = 1'b0;

  task automatic clear_mon();
    a_q.delete();
    a_t.delete();
    rdy_n = 0; rdy_t = -1; sure_n = 0; setup_n = 0; setup_t = -1;
    wait_n = 0; err_n = 0; err_t = -1;
    fire_rise_t = -1; fire_fall_t = -1;
  endtask

  always @(negedge clk) begin
    if (A != '0) begin
      a_q.push_back(A);
      a_t.push_back(cyc);
      if (a_prev != '0) wide_n++;
    end
    a_prev = A;
    if (ready)  begin rdy_n++;   rdy_t = cyc;   end
    if (sure)   sure_n++;
    if (setup)  begin setup_n++; setup_t = cyc; end
    if (wait_t) wait_n++;
`ifdef KEYPAD_MULTI_ERR_EN
    if (key_err) begin err_n++; err_t = cyc; end
`endif
    if (fire && !fire_prev) fire_rise_t = cyc;
    if (!fire && fire_prev) fire_fall_t = cyc;
    fire_prev = fire;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] a_val(input int i);
    return (a_q.size() > i) ? 32'(a_q[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] a_lat(input int i, input int t);
    return (a_t.size() > i) ? 32'(a_t[i] - t) : 32'hdead;
  endfunction

  int t0, t1;
  int tp[4];
  logic [9:0] dig[4];

  initial begin
    dig[0] = 10'h004; dig[1] = 10'h020; dig[2] = 10'h100; dig[3] = 10'h002;
    clear_mon();

    // Reset with digit 2 held
    rst_n = 1'b0; key_raw = 10'h004; btn_raw = '0;
    tick(3);
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_ctl", 32'({ready, sure, setup, wait_t, fire}), 32'h0);
`ifdef KEYPAD_MULTI_ERR_EN
    chk("rst_err", 32'(key_err), 32'h0);
`endif
    clear_mon();
    t0 = cyc; rst_n = 1'b1;
    tick(10); key_raw = '0; tick(12);
    chk("rst_npulse", 32'(a_q.size()), 32'd1);
    chk("rst_val", a_val(0), 32'h004);
    chk("rst_lat", a_lat(0, t0), 32'd7);

    // Clean digit sequence 2,5,8,1
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      tp[i] = cyc; key_raw = dig[i];
      tick(10); key_raw = '0; tick(10);
    end
    tick(5);
    chk("seq_npulse", 32'(a_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_val%0d", i), a_val(i), 32'(dig[i]));
      chk($sformatf("seq_lat%0d", i), a_lat(i, tp[i]), 32'd7);
    end

    // Press bounce then release bounce on digit 5
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      key_raw = 10'h020; tick(2); key_raw = '0; tick(2);
    end
    t0 = cyc; key_raw = 10'h020; tick(15);
    key_raw = '0; tick(2); key_raw = 10'h020; tick(2);
    key_raw = '0; tick(2); key_raw = 10'h020; tick(2);
    key_raw = '0; tick(15);
    chk("bnc_npulse", 32'(a_q.size()), 32'd1);
    chk("bnc_val", a_val(0), 32'h020);
    chk("bnc_lat", a_lat(0, t0), 32'd7);

    // Two keys at once
    clear_mon();
    t0 = cyc; key_raw = 10'h011; tick(10); key_raw = '0; tick(12);
    chk("multi_npulse", 32'(a_q.size()), 32'd0);
`ifdef KEYPAD_MULTI_ERR_EN
    chk("multi_err_n", 32'(err_n), 32'd1);
    chk("multi_err_lat", 32'(err_t - t0), 32'd7);
`endif

    // Ready press
    clear_mon();
    t0 = cyc; btn_raw = 5'b00001; tick(10); btn_raw = '0; tick(12);
    chk("ready_n", 32'(rdy_n), 32'd1);
    chk("ready_lat", 32'(rdy_t - t0), 32'd7);

    // Fire level
    clear_mon();
    t0 = cyc; btn_raw = 5'b10000; tick(10);
    chk("fire_mid", 32'(fire), 32'd1);
    tick(10); t1 = cyc; btn_raw = '0; tick(12);
    chk("fire_rise", 32'(fire_rise_t - t0), 32'd7);
    chk("fire_fall", 32'(fire_fall_t - t1), 32'd7);
    chk("fire_end", 32'(fire), 32'd0);

    // Short glitch on sure
    clear_mon();
    btn_raw = 5'b00010; tick(3); btn_raw = '0; tick(12);
    chk("glitch_sure", 32'(sure_n), 32'd0);

    // Digit 9 together with setup and wait_t
    clear_mon();
    t0 = cyc; key_raw = 10'h200; btn_raw = 5'b01100;
    tick(10); key_raw = '0; btn_raw = '0; tick(12);
    chk("sim_setup_n", 32'(setup_n), 32'd1);
    chk("sim_wait_n", 32'(wait_n), 32'd1);
    chk("sim_setup_lat", 32'(setup_t - t0), 32'd7);
    chk("sim_a_val", a_val(0), 32'h200);
    chk("sim_a_lat", a_lat(0, t0), 32'd7);

    // Reset while digit 3 is at cnt=2
    clear_mon();
    key_raw = 10'h008; tick(5);
    rst_n = 1'b0; key_raw = '0; tick(2);
    chk("rstmid_A", 32'(A), 32'h0);
    rst_n = 1'b1; tick(15);
    chk("rstmid_npulse", 32'(a_q.size()), 32'd0);

    // Recovery after reset
    clear_mon();
    t0 = cyc; key_raw = 10'h008; tick(10); key_raw = '0; tick(12);
    chk("recov_val", a_val(0), 32'h008);
    chk("recov_lat", a_lat(0, t0), 32'd7);

    chk("pulse_width", 32'(wide_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_conditioner.md
# keypad_conditioner

- Input conditioning stage directly upstream of `numeric_code_detonator`.
- Synchronises and debounces the raw 10-key digit pad and the five control pushbuttons.
- Drives the detonator's `A[9:0]` with exactly one single-cycle one-hot pulse per clean digit press.
- Drives `ready`/`setup`/`sure`/`wait_t` as single-cycle press pulses and `fire` as a debounced level.

## Interface
- `DB_CYCLES`, 250: consecutive stable synchronised samples required to accept a level change (10 ms at 25 kHz).
- `CNT_W`, 9: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `key_raw`  in  10  raw digit keys; bit i = digit i; 1 = pressed; asynchronous.
- `btn_raw`  in  5  raw controls, bit order {fire, wait_t, setup, sure, ready}; 1 = pressed; asynchronous.
- `A`  out  10  one-hot digit pulse, high for one cycle per accepted press.
- `ready`, `sure`, `setup`, `wait_t`  out  1 each  single-cycle pulse on debounced press.
- `fire`  out  1  debounced level of the fire button.
- `key_err`  out  1  present only with `KEYPAD_MULTI_ERR_EN`; see Configuration.

## Operation
- Every raw input passes through a 2-flop synchroniser before any other logic.
- The digit pad is handled as one 10-bit vector `ks` by a single FSM with an 8-bit-wide-enough counter `cnt` and a captured vector `cap`:
  - **IDLE**: if `ks != 0`, set `cap <= ks`, `cnt <= 0`, and go to DB_PRESS.
  - **DB_PRESS**:
    - If `ks != cap`, return to IDLE with no output.
    - Otherwise increment `cnt`. When `cnt == DB_CYCLES-1`, go to HELD.
    - On that transition, if `cap` is one-hot, pulse `A <= cap` for one cycle. If `cap` has 2 or more bits set, emit no digit.
  - **HELD**: if `ks == 0`, set `cnt <= 0` and go to DB_RELEASE.
  - **DB_RELEASE**:
    - If `ks != 0`, return to HELD. No new digit is emitted, so a release bounce cannot repeat a digit.
    - When `cnt == DB_CYCLES-1`, go to IDLE.
- Holding a key never auto-repeats. Exactly one pulse is emitted per press-release cycle.
- Each control button has its own bit debouncer with a stable state `s`:
  - When the synchronised input differs from `s` for DB_CYCLES consecutive cycles, `s` flips. Any agreeing sample clears the counter.
  - `ready`/`sure`/`setup`/`wait_t` pulse for one cycle on the 0→1 flip of `s`.
  - `fire` equals `s`.
- All outputs are registered.
- Reset values: `A = 0`; all pulses and `fire` = 0; `key_err = 0`; FSM in IDLE; counters, synchronisers and `s` = 0.
- Reset asserted mid-debounce discards the partial press. A key still held at reset release is treated as a new press.

## Timing
- Press latency: a raw level constant from edge k produces the output at edge k+DB_CYCLES+3 (2 synchroniser edges + DB_CYCLES + 1 output register edge).
- `fire` release latency is the same.
- A glitch shorter than DB_CYCLES cycles after synchronisation produces no output.
- Minimum spacing between two accepted digits is 2·DB_CYCLES+2 cycles (press debounce plus release debounce).
- Simultaneous events:
  - A control press and a digit press are independent; both outputs may pulse in the same cycle.
  - Two control buttons are independent.
- The counter saturates at DB_CYCLES-1 and never wraps.

## Configuration
- `KEYPAD_MULTI_ERR_EN` defined:
  - Port `key_err` exists.
  - It pulses for one cycle at the DB_PRESS→HELD transition when `cap` has 2 or more bits set, aligned with where `A` would have pulsed.
- Macro undefined: port `key_err` is absent, and multi-key presses are silently ignored.
- Digit behaviour is identical in both builds.

## Structure
- `keypad_pkg` holds:
  - the FSM state encoding (IDLE, DB_PRESS, HELD, DB_RELEASE);
  - the control-bit index constants BTN_READY=0, BTN_SURE=1, BTN_SETUP=2, BTN_WAIT=3, BTN_FIRE=4;
  - the default DB_CYCLES.
- Sub-module `btn_debounce`: synchroniser, counter, stable state and rise pulse. Instantiated 5 times with parameter DB_CYCLES.
- The digit FSM lives in the top level.

## Test plan
Build the bench with DB_CYCLES=4.
- **Reset**: hold `rst_n=0` with `key_raw=10'h004` → all outputs 0. Release reset, keep the key held → exactly one `A=10'h004` pulse 7 edges later.
- **Clean digit sequence**: press 2, 5, 8, 1, each held 10 cycles with 10 idle cycles between → `A` pulses 10'h004, 10'h020, 10'h100, 10'h002 in order, each 1 cycle wide.
- **Bounce**:
  - Digit 5 toggling every 2 cycles for 12 cycles, then held → exactly one `A=10'h020` pulse, 7 edges after the final stable edge.
  - Release bounce → no second pulse.
- **Multi-key**: `key_raw=10'h011` held 10 cycles → `A` stays 0. With `KEYPAD_MULTI_ERR_EN`, one `key_err` pulse.
- **Controls**:
  - `btn_raw[0]` (ready) held 10 cycles → one `ready` pulse.
  - `btn_raw[4]` (fire) held 20 cycles → `fire` high from edge 7 until 7 edges after release.
  - A 3-cycle glitch on `btn_raw[1]` → no `sure` pulse.
- **Reset mid-debounce**: assert `rst_n=0` at cnt=2 of a digit-3 press, release after 2 cycles with the key released → no `A` pulse.
